// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encoding and architectural constants.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_HALT    = 2'd2,
    ST_STEP    = 2'd3
  } state_e;

  localparam logic [4:0]  REG_X0   = 5'd0;
  localparam logic [31:0] NOP_INSN = 32'h0000_0033;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use comparator: the instruction in ID reads a register
// that a load currently in EX is about to write.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       use_rs1_ID,
  input  logic       use_rs2_ID,
  input  logic [4:0] rd_EX,
  input  logic       mem_read_EX,
  output logic       load_use
);

  assign load_use = mem_read_EX && (rd_EX != REG_X0) &&
                    ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                     (use_rs2_ID && (rs2_ID == rd_EX)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush strobes for load-use, taken
// branches, multi-cycle mul/div and debug halt/step, plus saturating statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             mem_read_EX,
  input  logic             br_taken_EX,
  input  logic             md_start_EX,
  input  logic             md_done,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             stall_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             halted,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W    = $clog2(MD_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_e            state_r;
  state_e            state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              step_r;
  logic              md_err_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              load_use_s;
  logic              run_mode_s;
  logic              busy_s;
  logic              timeout_s;
  // stall_s: {MEM_WB, EX_MEM, ID_EX, IF_ID, PC}; flush_s: {EX_MEM, ID_EX, IF_ID}
  logic [4:0]        stall_s;
  logic [2:0]        flush_s;

  hazard_detect u_detect (
    .rs1_ID      (rs1_ID),
    .rs2_ID      (rs2_ID),
    .use_rs1_ID  (use_rs1_ID),
    .use_rs2_ID  (use_rs2_ID),
    .rd_EX       (rd_EX),
    .mem_read_EX (mem_read_EX),
    .load_use    (load_use_s)
  );

  // Next-state selection and stall/flush generation.
  always_comb begin
    state_nxt_s = state_r;
    run_mode_s  = 1'b0;
    busy_s      = 1'b0;
    timeout_s   = 1'b0;
    stall_s     = 5'b00000;
    flush_s     = 3'b000;
    case (state_r)
      ST_RUN, ST_STEP: begin
        run_mode_s = 1'b1;
        busy_s     = md_start_EX && !md_done && !br_taken_EX;
        if (busy_s) begin
          state_nxt_s = ST_MD_WAIT;
        end else if ((state_r == ST_STEP) || halt_req) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MD_WAIT: begin
        // The done cycle behaves like RUN so the result flows into EX/MEM.
        busy_s     = !md_done;
        run_mode_s = md_done;
        if (md_done) begin
          state_nxt_s = (step_r && halt_req) ? ST_HALT : ST_RUN;
        end else if (wait_cnt_r == WAIT_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_MD_WAIT;
        end
      end
      ST_HALT: begin
        stall_s = 5'b11111;
        if (step_req) begin
          state_nxt_s = ST_STEP;
        end else if (!halt_req) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase

    if (busy_s) begin
      stall_s = 5'b00111;
      flush_s = 3'b100;
    end else if (run_mode_s && br_taken_EX) begin
      flush_s = 3'b011;
    end else if (run_mode_s && load_use_s) begin
      stall_s = 5'b00011;
      flush_s = 3'b010;
    end else begin
      flush_s = flush_s;
    end
  end

  // State, wait counter, sticky error and saturating statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      step_r      <= 1'b0;
      md_err_r    <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= (state_r == ST_MD_WAIT) ? (wait_cnt_r + WAIT_W'(1)) : {WAIT_W{1'b0}};
      // Remember whether a mul/div wait was entered from a single step.
      if (state_r != ST_MD_WAIT) begin
        step_r <= (state_r == ST_STEP);
      end
      md_err_r <= md_err_r | timeout_s;
      if (stall_s[0] && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if ((flush_s[0] || flush_s[1]) && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_PC     = stall_s[0] & ~rst;
  assign stall_IF_ID  = stall_s[1] & ~rst;
  assign stall_ID_EX  = stall_s[2] & ~rst;
  assign stall_EX_MEM = stall_s[3] & ~rst;
  assign stall_MEM_WB = stall_s[4] & ~rst;
  assign flush_IF_ID  = flush_s[0] & ~rst;
  assign flush_ID_EX  = flush_s[1] & ~rst;
  assign flush_EX_MEM = flush_s[2] & ~rst;
  assign halted       = (state_r == ST_HALT);
  assign md_err       = md_err_r;
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core. Generates per-stage stall (hold) and flush (bubble) strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers load-use hazards, taken branches/jumps resolved in EX, multi-cycle mul/div operations in EX, and a debug halt/single-step handshake. Keeps saturating stall and flush statistics for the debug unit.

## Interface
Parameters:
- MD_TIMEOUT, 64: maximum MD_WAIT cycles before md_err is raised and the wait is abandoned.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs1_ID, rs2_ID  in  5 each  source registers of the instruction in ID.
- use_rs1_ID, use_rs2_ID  in  1 each  instruction in ID reads rs1/rs2.
- rd_EX  in  5  destination register of the instruction in EX.
- mem_read_EX  in  1  instruction in EX is a load.
- br_taken_EX  in  1  branch/jump in EX redirects the PC this cycle.
- md_start_EX  in  1  mul/div instruction is in EX (level, held while frozen).
- md_done  in  1  mul/div result valid this cycle.
- halt_req  in  1  debug halt request (level).
- step_req  in  1  single-step pulse, honoured only when halted.
- stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB  out  1 each  hold the named register.
- flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  load NOP/zero into the named register.
- halted  out  1  state is HALT.
- md_err  out  1  sticky timeout flag, cleared only by rst.
- stall_cnt, flush_cnt  out  CNT_W each  cycle counts, saturating at all-ones.

## Operation
- FSM states: RUN, MD_WAIT, HALT, STEP. Reset state is RUN.
- Load-use hazard: mem_read_EX && rd_EX != 0 && ((use_rs1_ID && rs1_ID == rd_EX) || (use_rs2_ID && rs2_ID == rd_EX)).
  - Response: stall_PC, stall_IF_ID and flush_ID_EX for that cycle.
- Taken branch: br_taken_EX sets flush_IF_ID and flush_ID_EX.
  - It overrides a load-use hazard in the same cycle: no stall.
  - In RUN, a simultaneous md_start_EX is ignored.
- Mul/div busy, defined as md_start_EX && !md_done in RUN, or !md_done in MD_WAIT.
  - Response: stall_PC, stall_IF_ID, stall_ID_EX and flush_EX_MEM.
  - Load-use detection is masked while busy.
- RUN transitions:
  - busy → MD_WAIT.
  - else halt_req → HALT.
  - else stay in RUN.
- MD_WAIT transitions:
  - md_done → RUN. The done cycle itself is unstalled.
  - Wait counter reaching MD_TIMEOUT → set md_err and go to RUN.
  - halt_req during MD_WAIT is deferred until after exit.
- HALT:
  - All five stall outputs are 1 and all flush outputs are 0.
  - step_req → STEP.
  - else !halt_req → RUN.
- STEP: exactly one cycle of RUN behaviour (hazard logic active), then HALT.
  - If that cycle is mul/div busy, go to MD_WAIT instead. Return to HALT afterward if halt_req is still high.
- Counters:
  - stall_cnt increments on every cycle where stall_PC = 1.
  - flush_cnt increments on every cycle where flush_IF_ID or flush_ID_EX = 1.

## Timing
- All stall/flush outputs are combinational from the current state and inputs, and are consumed by the pipeline registers on the same edge.
- State, wait counter, md_err and statistics are registered.
- While rst = 1 and after reset:
  - state = RUN, wait counter = 0.
  - stall_cnt = flush_cnt = 0, md_err = 0, halted = 0.
  - All stall/flush outputs are 0 while rst is high.
- Load-use costs exactly one bubble. The hazard clears the next cycle because the load has advanced to MEM.
- Taken branch costs two bubbles, both inserted in the resolving cycle.
- Mul/div with done after N cycles (N ≥ 1): stall asserted for N−1 cycles, then EX/MEM captures the result on the done cycle.
- Halt latency is one cycle after halt_req is sampled in RUN.
- step_req in any state other than HALT is ignored.
- Counters saturate; they do not wrap.

## Structure
- Shared core package holds:
  - FSM state enum (RUN, MD_WAIT, HALT, STEP).
  - Constants: x0 register index, NOP encoding 32'h0000_0033.
- One sub-module, hazard_detect: purely combinational load-use comparator. FSM, counters and output muxing stay in hazard_ctrl.

## Test plan
- Load then dependent add: mem_read_EX=1, rd_EX=5, rs1_ID=5, use_rs1_ID=1 → one cycle of stall_PC=stall_IF_ID=flush_ID_EX=1; stall_cnt=1.
- Same stimulus with rd_EX=0 → no stall. Same stimulus with br_taken_EX=1 → flush_IF_ID=flush_ID_EX=1, stall_PC=0, flush_cnt=1.
- md_start_EX held, md_done after 4 cycles → 3 stall cycles with flush_EX_MEM=1, then RUN; stall_cnt=3.
- md_done never arrives, MD_TIMEOUT=8 → md_err=1 after 8 MD_WAIT cycles, state RUN, md_err stays 1.
- halt_req=1 in RUN → halted=1 next cycle, all stalls 1. Two step_req pulses → exactly two one-cycle advances. halt_req=0 → RUN.
- rst asserted mid-MD_WAIT with stall_cnt=5 → outputs drop immediately; state RUN, counters 0, md_err 0.
